alu_uart_ctrl: RTL
==================

# alu_uart_ctrl

Byte-serial sequencer for the 8-bit ALU. It collects three received bytes in order: operand A, operand B, then the opcode. It holds them as registered ALU inputs, latches the ALU result one cycle later and hands it to the UART transmitter, waiting for transmit completion before accepting a new frame. It sits between the UART rx/tx cores and the combinational ALU at the board top level.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50_000_000: maximum idle clocks between bytes of one frame. Used only with ALU_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte; valid in the cycle rx_done is high
- rx_done  in  1  one-cycle strobe, byte available
- alu_z  in  8  ALU result (combinational from alu_a/alu_b/alu_op)
- tx_done  in  1  one-cycle strobe, transmitter finished current byte
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_op  out  8  registered opcode to ALU
- tx_data  out  8  registered result byte to transmitter
- tx_start  out  1  one-cycle strobe, start transmission of tx_data
- frame_err  out  1  one-cycle strobe: invalid opcode or inter-byte timeout
- overrun  out  1  one-cycle strobe: rx_done arrived while busy, byte dropped

## Operation
- States are WAIT_A, WAIT_B, WAIT_OP, EXEC and WAIT_TX.
- WAIT_A: rx_done captures rx_data into alu_a, then goes to WAIT_B.
- WAIT_B: rx_done captures rx_data into alu_b, then goes to WAIT_OP.
- WAIT_OP: rx_done with rx_data in 0x20..0x27 captures the opcode into alu_op, then goes to EXEC.
  - Any other value leaves alu_op unchanged, pulses frame_err and returns to WAIT_A.
- EXEC: lasts exactly one cycle. On exit, tx_data <= alu_z and tx_start <= 1, then goes to WAIT_TX.
- WAIT_TX: tx_done returns to WAIT_A.
- Valid opcodes:
  - 0x20 add
  - 0x21 srl
  - 0x22 sub
  - 0x23 sra
  - 0x24 and
  - 0x25 or
  - 0x26 xor
  - 0x27 nor
- The controller does no arithmetic. The result is the ALU's 8-bit two's-complement wrap value, passed through unchanged.
- An rx_done seen in EXEC or WAIT_TX drops the byte, pulses overrun and leaves the state unchanged.
- alu_a, alu_b and alu_op hold their values after a frame completes, until the next capture.

## Timing
- Reset value of every output is 0. State resets to WAIT_A. Reset in any state aborts the frame immediately, with no tx_start.
- Let the opcode rx_done be high in cycle n:
  - alu_op updates at edge n+1, and cycle n+1 is EXEC.
  - At edge n+2, tx_data and tx_start are updated; tx_start is high during cycle n+2 only.
- tx_done is sampled only in WAIT_TX. A tx_done in any other state is ignored.
- tx_done in cycle m gives state WAIT_A at edge m+1. An rx_done in cycle m is an overrun.
- frame_err and overrun are registered: each is high for one cycle after the triggering edge.
- Byte to next-capture throughput is one byte per rx_done. There is no back-pressure on rx.

## Configuration
- ALU_CTRL_TIMEOUT_EN defined:
  - A counter runs in WAIT_B and WAIT_OP and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 with no rx_done pulses frame_err and returns the state to WAIT_A.
  - rx_done in the terminal-count cycle wins: the byte is accepted and no error is raised.
- ALU_CTRL_TIMEOUT_EN undefined: no counter is built, TIMEOUT_CYCLES is unused, and a partial frame waits indefinitely.

## Structure
- Shared package alu_ctrl_pkg holds:
  - the state enum
  - opcode constants OP_ADD..OP_NOR (0x20..0x27)
  - OP_MIN/OP_MAX for the validity check
- Sub-module alu_ctrl_timer exists only under the macro: a loadable down-counter with clear and terminal-count outputs.

## Test plan
The bench connects the real ALU to alu_a/alu_b/alu_op/alu_z.
- Bytes 0x05, 0x03, 0x20 -> tx_start pulse 2 cycles after the third rx_done, with tx_data=0x08; tx_done returns the state to WAIT_A.
- Bytes 0x03, 0x05, 0x22 -> tx_data=0xFE. Bytes 0x80, 0x02, 0x23 -> tx_data=0xE0. Bytes 0x80, 0x02, 0x21 -> tx_data=0x20.
- Bytes 0x01, 0x02, 0x30 -> frame_err pulse, no tx_start, alu_op still 0x00. A following 0x01, 0x02, 0x25 frame -> tx_data=0x03.
- rx_done 0x55 during WAIT_TX -> overrun pulse and alu_a unchanged. After tx_done, the next frame completes normally.
- rst_n low in WAIT_OP, then bytes 0x0F, 0xF0, 0x26 -> all outputs 0 during reset, then tx_data=0xFF.
- With the macro defined and TIMEOUT_CYCLES=16: byte 0x11, then silence for 16 cycles -> frame_err pulse and state WAIT_A. Next: byte 0x11, then 0x22 on the terminal-count cycle -> accepted, no error.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU byte-serial controller.
//   state_t        controller FSM states
//   OP_ADD..OP_NOR opcode byte values understood by the ALU
//   OP_MIN/OP_MAX  inclusive bounds of the valid opcode range
//   op_valid()     opcode range check
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SRL = 8'h21;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_SRA = 8'h23;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;

  localparam logic [7:0] OP_MIN = OP_ADD;
  localparam logic [7:0] OP_MAX = OP_NOR;

  function automatic logic op_valid(input logic [7:0] op);
    return (op >= OP_MIN) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_ctrl_timer.sv
// alu_ctrl_timer: loadable down-counter for the inter-byte timeout.
// Only instantiated when ALU_CTRL_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  clock, async active-low reset (counter resets to LOAD_VAL)
//   load        reload LOAD_VAL (has priority over en)
//   en          decrement by one, saturating at zero
//   tc          terminal count: counter is zero
module alu_ctrl_timer #(
  parameter int W = 4,
  parameter logic [W-1:0] LOAD_VAL = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= LOAD_VAL;
    else if (load)       cnt <= LOAD_VAL;
    else if (en && !tc)  cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: byte-serial sequencer between UART rx/tx and the 8-bit ALU.
// Collects operand A, operand B and opcode bytes, drives them as registered
// ALU inputs, latches the combinational result one cycle later and starts a
// UART transmission, then waits for tx_done before taking a new frame.
// Optional macro ALU_CTRL_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYCLES clocks while a frame is partially received.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   rx_data/rx_done   received byte and its one-cycle strobe
//   alu_z             ALU result (combinational from alu_a/alu_b/alu_op)
//   tx_done           transmitter finished strobe
//   alu_a/b/op        registered ALU inputs
//   tx_data/tx_start  result byte and one-cycle start strobe
//   frame_err         one-cycle strobe: bad opcode or timeout
//   overrun           one-cycle strobe: byte dropped while busy
module alu_uart_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic [7:0] alu_z,
  input  logic       tx_done,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_op,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       frame_err,
  output logic       overrun
);

  state_t state, state_nx;
  logic   timeout;
  logic   cap_a, cap_b, cap_op, start_d, ferr_d, ovr_d;

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

  logic tmr_en, tmr_load, tmr_tc;

  // Counter is held at its load value outside a partial frame, so the
  // first WAIT_B cycle already starts the full TIMEOUT_CYCLES window.
  assign tmr_en   = (state == WAIT_B) || (state == WAIT_OP);
  assign tmr_load = !tmr_en || rx_done;
  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign timeout  = tmr_en && tmr_tc && !rx_done;

  alu_ctrl_timer #(.W(TW), .LOAD_VAL(TLOAD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_A:  if (rx_done) state_nx = WAIT_B;
      WAIT_B:  if (rx_done) state_nx = WAIT_OP;
               else if (timeout) state_nx = WAIT_A;
      WAIT_OP: if (rx_done) state_nx = op_valid(rx_data) ? EXEC : WAIT_A;
               else if (timeout) state_nx = WAIT_A;
      EXEC:    state_nx = WAIT_TX;
      WAIT_TX: if (tx_done) state_nx = WAIT_A;
      default: state_nx = WAIT_A;
    endcase
  end

  // Output decode: capture enables and next values of the strobes
  always_comb begin
    cap_a   = (state == WAIT_A)  && rx_done;
    cap_b   = (state == WAIT_B)  && rx_done;
    cap_op  = (state == WAIT_OP) && rx_done && op_valid(rx_data);
    start_d = (state == EXEC);
    ferr_d  = ((state == WAIT_OP) && rx_done && !op_valid(rx_data)) || timeout;
    ovr_d   = rx_done && ((state == EXEC) || (state == WAIT_TX));
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (cap_a)   alu_a   <= rx_data;
      if (cap_b)   alu_b   <= rx_data;
      if (cap_op)  alu_op  <= rx_data;
      if (start_d) tx_data <= alu_z;
      tx_start  <= start_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
    end
  end

endmodule
